bus_copy_dma: RTL and testbench

Copy engine that initiates transfers on the toggle-handshake memory bus (run/done). Given a source address, a destination address and a word count, it moves 16-bit words by issuing read-then-write transaction pairs to a responder such as `memory`. It sits beside the CPU as a second bus initiator and drives its own bus port. Arbitration is outside this block.

---
 rtl/bus_copy_dma.sv | 156 +++++++++++++++
 tb/tb_bus_copy_dma.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_copy_dma.sv
// Word copy engine that initiates read/write pairs on the toggle-handshake bus.
// One transaction is outstanding at a time; abort stops only after a write.
module bus_copy_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_left,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [1:0]        bus_cmd,
  output logic              bus_run,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_done
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } state_t;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        cmd_q, cmd_d;
  logic              run_q, run_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              abrt_q, abrt_d;
  logic              ack;
  logic              stop;
  logic              last;

  assign ack  = (run_q == bus_done);
  assign stop = abort || abrt_q;
  assign last = (left_q == LEN_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      left_q    <= '0;
      addr_q    <= '0;
      cmd_q     <= CMD_NOP;
      run_q     <= 1'b0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      abrt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      left_q    <= left_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      run_q     <= run_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      abrt_q    <= abrt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    left_d    = left_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    run_d     = run_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    abrt_d    = abrt_q;
    unique case (state_q)
      IDLE: begin
        if (start && ack) begin
          src_d     = {src_addr[ADDR_W-1:1], 1'b0};
          dst_d     = {dst_addr[ADDR_W-1:1], 1'b0};
          left_d    = len;
          aborted_d = 1'b0;
          abrt_d    = 1'b0;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = {src_addr[ADDR_W-1:1], 1'b0};
            cmd_d   = CMD_RD;
            run_d   = ~run_q;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (abort) abrt_d = 1'b1;
        if (ack) begin
          wdata_d = bus_rd_data;
          addr_d  = dst_q;
          cmd_d   = CMD_WR;
          run_d   = ~run_q;
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (ack) begin
          left_d = left_q - LEN_W'(1);
          src_d  = src_q + ADDR_W'(2);
          dst_d  = dst_q + ADDR_W'(2);
          if (last || stop) begin
            // finishing the final word normally is not an early end
            cmd_d     = CMD_NOP;
            done_d    = 1'b1;
            aborted_d = stop && !last;
            state_d   = IDLE;
          end else begin
            addr_d  = src_q + ADDR_W'(2);
            cmd_d   = CMD_RD;
            run_d   = ~run_q;
            state_d = RD_WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign words_left  = left_q;
  assign bus_addr    = addr_q;
  assign bus_cmd     = cmd_q;
  assign bus_run     = run_q;
  assign bus_wr_data = wdata_q;

endmodule

// File: tb/tb_bus_copy_dma.sv
// Directed bench for bus_copy_dma with a toggle-handshake memory responder.
// The responder inserts a programmable number of wait cycles per transaction.
module tb_bus_copy_dma;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] words_left;
  logic [15:0] bus_addr;
  logic [1:0]  bus_cmd;
  logic        bus_run;
  logic [15:0] bus_wr_data;
  logic [15:0] bus_rd_data = '0;
  logic        bus_done = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  bus_copy_dma dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .words_left (words_left),
    .bus_addr   (bus_addr),
    .bus_cmd    (bus_cmd),
    .bus_run    (bus_run),
    .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data),
    .bus_done   (bus_done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [int];
  logic [17:0] op_q [$];
  int          wait_cyc = 0;
  int          wcnt = 0;
  int          ra;

  function automatic logic [15:0] initv(input int a);
    case (a)
      'h10:    return 16'h1111;
      'h12:    return 16'h2222;
      'h14:    return 16'h3333;
      default: return 16'(a) ^ 16'hA5A5;
    endcase
  endfunction

  function automatic logic [15:0] rdval(input int a);
    if (mem.exists(a)) return mem[a];
    return initv(a);
  endfunction

  always @(posedge clk) begin
    if (bus_run != bus_done) begin
      if (wcnt < wait_cyc) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
        ra = int'({bus_addr[15:1], 1'b0});
        if (bus_cmd == 2'b01) bus_rd_data <= rdval(ra);
        else if (bus_cmd == 2'b10) mem[ra] = bus_wr_data;
        op_q.push_back({bus_cmd, bus_addr});
        bus_done <= ~bus_done;
      end
    end
  end

  logic        mon_en = 1'b1;
  logic        outst = 1'b0;
  logic [1:0]  s_cmd = '0;
  logic [15:0] s_addr = '0;
  logic [15:0] s_wd = '0;
  int          stab_err = 0;

  always @(negedge clk) begin
    if (!mon_en) begin
      outst <= 1'b0;
    end else if (bus_run != bus_done) begin
      if (!outst) begin
        outst  <= 1'b1;
        s_cmd  <= bus_cmd;
        s_addr <= bus_addr;
        s_wd   <= bus_wr_data;
      end else if (bus_cmd != s_cmd || bus_addr != s_addr ||
                   bus_wr_data != s_wd) begin
        stab_err <= stab_err + 1;
      end
    end else begin
      outst <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ops(input string tag, input logic [17:0] exp [$]);
    check({tag, "_nops"}, op_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < op_q.size(); i++)
      check($sformatf("%s_op%0d", tag, i), op_q[i], exp[i]);
  endtask

  // Latency is the k of edge E(k) after which done is first seen high.
  task automatic run_job(input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] n, input int abort_at,
                         input int restart_at, output int lat);
    int k;
    op_q.delete();
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len      = n;
    start    = 1'b1;
    @(posedge clk);
    k   = 0;
    lat = -1;
    while (k < 400) begin
      @(negedge clk);
      start = (k == restart_at);
      abort = (k == abort_at);
      if (k == restart_at) begin
        src_addr = 16'h0BAC;
        dst_addr = 16'h0CAC;
        len      = 16'd7;
      end
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk);
      k++;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  int lat;
  logic r0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_words_left", words_left, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_cmd", bus_cmd, 0);
    check("rst_bus_run", bus_run, 0);
    check("rst_bus_wr_data", bus_wr_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    run_job(16'h0010, 16'h0040, 16'd3, -1, -1, lat);
    check("t1_latency", lat, 12);
    check("t1_aborted", aborted, 0);
    check("t1_words_left", words_left, 0);
    check("t1_busy", busy, 0);
    check("t1_mem40", rdval('h40), 16'h1111);
    check("t1_mem42", rdval('h42), 16'h2222);
    check("t1_mem44", rdval('h44), 16'h3333);
    check_ops("t1", '{18'h10010, 18'h20040, 18'h10012,
                      18'h20042, 18'h10014, 18'h20044});

    r0 = bus_run;
    run_job(16'h0020, 16'h0060, 16'd0, -1, -1, lat);
    check("t2_latency", lat, 0);
    check("t2_bus_run", bus_run, r0);
    check("t2_nops", op_q.size(), 0);

    run_job(16'hFFFF, 16'h0101, 16'd2, -1, -1, lat);
    check("t3_latency", lat, 8);
    check("t3_mem100", rdval('h100), 16'h5A5B);
    check("t3_mem102", rdval('h102), 16'hA5A5);
    check_ops("t3", '{18'h1FFFE, 18'h20100, 18'h10000, 18'h20102});

    run_job(16'h0200, 16'h0300, 16'd5, 4, -1, lat);
    check("t4_latency", lat, 8);
    check("t4_aborted", aborted, 1);
    check("t4_words_left", words_left, 3);
    check("t4_mem302", rdval('h302), 16'hA7A7);
    check("t4_mem304_untouched", mem.exists('h304), 0);
    check_ops("t4", '{18'h10200, 18'h20300, 18'h10202, 18'h20302});

    wait_cyc = 3;
    run_job(16'h0400, 16'h0500, 16'd2, -1, 3, lat);
    check("t6_latency", lat, 20);
    check("t6_aborted", aborted, 0);
    check("t6_words_left", words_left, 0);
    check("t6_mem500", rdval('h500), 16'hA1A5);
    check("t6_mem502", rdval('h502), 16'hA1A7);
    check_ops("t6", '{18'h10400, 18'h20500, 18'h10402, 18'h20502});

    wait_cyc = 8;
    @(negedge clk);
    src_addr = 16'h0600;
    dst_addr = 16'h0700;
    len      = 16'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("t5_in_write", {busy, bus_cmd}, 3'b110);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_run", bus_run, 0);
    check("t5_rst_cmd", bus_cmd, 0);
    check("t5_rst_addr", bus_addr, 0);
    check("t5_rst_left", words_left, 0);
    @(negedge clk);
    reset_n  = 1'b1;
    src_addr = 16'h0600;
    dst_addr = 16'h0800;
    len      = 16'd1;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("t5_start_ignored", busy, 0);
    check("t5_run_held", bus_run, 0);
    for (int i = 0; i < 50 && bus_done; i++) @(negedge clk);
    check("t5_nop_done", bus_done, 0);
    check("t5_mem700_untouched", mem.exists('h700), 0);
    mon_en = 1'b1;
    run_job(16'h0600, 16'h0800, 16'd1, -1, -1, lat);
    check("t5_latency", lat, 20);
    check("t5_mem800", rdval('h800), 16'hA3A5);
    check_ops("t5", '{18'h10600, 18'h20800});

    check("stability", stab_err, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
